// File: rtl/lzs_copy_engine.sv
// lzs_copy_engine: LZS decode copy engine between token parser and history RAM.
// Define LZS_COPY_OUT_REG_EN to register the output through a 2-entry skid buffer.
module lzs_copy_engine #(
  parameter int AW    = 11,
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic             tok_literal,
  input  logic [7:0]       tok_data,
  input  logic [AW-1:0]    tok_offset,
  input  logic [LEN_W-1:0] tok_length,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [AW-1:0]    ram_read_address,
  input  logic [7:0]       ram_read_data,
  output logic [AW-1:0]    ram_write_address,
  output logic [7:0]       ram_write_data,
  output logic             ram_write_valid,
  output logic             busy,
  output logic             err
);

  typedef enum logic {IDLE, COPY} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     off_q, off_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              pending_q, pending_d;
  logic              err_q, err_d;

  // Internal byte stream feeding either the port directly or the skid buffer
  logic              eng_valid;
  logic              eng_ready;
  logic [7:0]        eng_data;
  logic              retire;
  logic              tok_illegal;

  assign tok_illegal = (tok_offset == '0) || (tok_length == '0);
  assign retire      = eng_valid && eng_ready;

  // The copy read address already anticipates the byte retiring this cycle
  assign ram_read_address  = wptr_q + AW'(retire) - off_q;
  assign ram_write_address = wptr_q;
  assign ram_write_data    = eng_data;
  assign ram_write_valid   = retire;
  assign busy              = (state_q == COPY);
  assign err               = err_q;

  // Byte source selection and token handshake
  always_comb begin
    eng_valid = 1'b0;
    eng_data  = tok_data;
    tok_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        eng_valid = tok_valid && tok_literal;
        tok_ready = tok_literal ? eng_ready : 1'b1;
      end
      COPY: begin
        eng_valid = pending_q;
        eng_data  = ram_read_data;
      end
      default: ;
    endcase
  end

  // Next-state logic for the copy FSM and history pointer
  always_comb begin
    state_d   = state_q;
    wptr_d    = retire ? wptr_q + AW'(1) : wptr_q;
    off_d     = off_q;
    remain_d  = remain_q;
    pending_d = pending_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (tok_valid && !tok_literal) begin
          if (tok_illegal) begin
            err_d = 1'b1;
          end else begin
            off_d     = tok_offset;
            remain_d  = tok_length;
            pending_d = 1'b0;
            state_d   = COPY;
          end
        end
      end
      COPY: begin
        if (retire) begin
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            pending_d = 1'b0;
            state_d   = IDLE;
          end
        end else begin
          pending_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Copy FSM state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      off_q     <= '0;
      remain_q  <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      off_q     <= off_d;
      remain_q  <= remain_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

`ifdef LZS_COPY_OUT_REG_EN
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] e0_q, e0_d;
  logic [7:0] e1_q, e1_d;
  logic       pop;
  logic [1:0] slot;

  assign eng_ready = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = e0_q;
  assign pop       = out_valid && out_ready;
  assign slot      = cnt_q - {1'b0, pop};

  // Skid buffer: e0 is the head, pushes land behind whatever survives the pop
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q + {1'b0, retire} - {1'b0, pop};
    if (pop) e0_d = e1_q;
    if (retire) begin
      if (slot == 2'd0) e0_d = eng_data;
      else              e1_d = eng_data;
    end
  end

  // Skid buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      e0_q  <= 8'd0;
      e1_q  <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end
`else
  assign eng_ready = out_ready;
  assign out_valid = eng_valid;
  assign out_data  = eng_data;
`endif

endmodule

// File: tb/tb_lzs_copy_engine.sv
// tb_lzs_copy_engine: randomized and directed bench for lzs_copy_engine.
// Includes a write-first history RAM model and an LZ reference decoder.
module tb_lzs_copy_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tok_valid = 1'b0;
  logic        tok_ready;
  logic        tok_literal = 1'b1;
  logic [7:0]  tok_data = 8'd0;
  logic [10:0] tok_offset = 11'd0;
  logic [11:0] tok_length = 12'd0;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [10:0] ram_read_address;
  logic [7:0]  ram_read_data;
  logic [10:0] ram_write_address;
  logic [7:0]  ram_write_data;
  logic        ram_write_valid;
  logic        busy;
  logic        err;

  lzs_copy_engine #(.AW(11), .LEN_W(12)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_literal(tok_literal), .tok_data(tok_data),
    .tok_offset(tok_offset), .tok_length(tok_length),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
    .ram_read_address(ram_read_address),
    .ram_read_data(ram_read_data),
    .ram_write_address(ram_write_address),
    .ram_write_data(ram_write_data),
    .ram_write_valid(ram_write_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // History RAM: write lands before the registered read sees it
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_write_valid) mem[ram_write_address] <= ram_write_data;
    if (ram_write_valid && ram_write_address == ram_read_address)
      ram_read_data <= ram_write_data;
    else
      ram_read_data <= mem[ram_read_address];
  end

  // Downstream readiness: 0 always, 1 pattern 1,0,0,1, 2 random
  int bp_mode = 0;
  int bp_i = 0;
  int bp_pat [4] = '{1, 0, 0, 1};
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1: begin
          out_ready = (bp_pat[bp_i % 4] != 0);
          bp_i++;
        end
        2: out_ready = ($urandom % 3) != 0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Observed stream
  logic [7:0]  got_d [$];
  logic [10:0] got_a [$];
  bit          got_w [$];
  int          got_c [$];
  int          wr_cnt = 0;
  int          stall_viol = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_d = 0;

  always @(negedge clk) begin
    if (ram_write_valid) wr_cnt++;
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_a.push_back(ram_write_address);
      got_w.push_back(ram_write_valid && ram_write_data == out_data);
      got_c.push_back(cyc);
    end
    if (prev_stall && out_valid && out_data !== prev_d) stall_viol++;
    prev_stall = !rst && busy && out_valid && !out_ready;
    prev_d = out_data;
  end

  // Reference decoder: plain LZ semantics over a 2048-byte window
  logic [7:0]  mh [0:2047];
  logic [10:0] mw = 0;
  logic [7:0]  exp_d [$];
  logic [10:0] exp_a [$];

  task automatic model_tok(input bit lit, input logic [7:0] d,
                           input logic [10:0] o,
                           input logic [11:0] l);
    logic [7:0] b;
    if (lit) begin
      exp_d.push_back(d);
      exp_a.push_back(mw);
      mh[mw] = d;
      mw = mw + 11'd1;
    end else if (o != 0 && l != 0) begin
      for (int i = 0; i < int'(l); i++) begin
        b = mh[mw - o];
        exp_d.push_back(b);
        exp_a.push_back(mw);
        mh[mw] = b;
        mw = mw + 11'd1;
      end
    end
  endtask

  task automatic clear_q();
    got_d.delete(); got_a.delete(); got_w.delete(); got_c.delete();
    exp_d.delete(); exp_a.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tok_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mw = 0;
    clear_q();
  endtask

  // Present one token and hold it until accepted; acc = accept cycle
  task automatic send(input bit lit, input logic [7:0] d,
                      input logic [10:0] o, input logic [11:0] l,
                      output int acc);
    int n;
    acc = -1;
    n = 0;
    tok_valid = 1'b1;
    tok_literal = lit;
    tok_data = d;
    tok_offset = o;
    tok_length = l;
    forever begin
      @(negedge clk);
      if (tok_ready) begin
        acc = cyc;
        break;
      end
      n++;
      if (n > 500) break;
    end
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    if (acc < 0) begin
      tests++; fails++;
      $display("FAIL send_timeout got no accept want accept");
    end else begin
      model_tok(lit, d, o, l);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++; fails++;
      $display("FAIL idle_timeout got busy=1 want 0");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bp_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy, out_valid, ram_write_valid, err} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags got %b want 0000",
               {busy, out_valid, ram_write_valid, err});
    end
    tests++;
    if (tok_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_tok_ready got %b want 1", tok_ready);
    end
    tests++;
    if (ram_write_address !== 11'd0) begin
      fails++;
      $display("FAIL reset_wptr got %0d want 0", ram_write_address);
    end
    do_reset();
  endtask

  task automatic test_literals();
    int acc [3];
    logic [7:0] lits [3] = '{8'h41, 8'h42, 8'h43};
    do_reset();
    for (int i = 0; i < 3; i++) send(1, lits[i], 0, 0, acc[i]);
    @(negedge clk);
    tests++;
    if (got_d.size() != 3) begin
      fails++;
      $display("FAIL lit_count got %0d want 3", got_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (got_d[i] !== lits[i] || got_a[i] !== 11'(i)
            || got_c[i] != acc[i] || !got_w[i]) begin
          fails++;
          $display("FAIL lit_%0d got %h@%0d c%0d want %h@%0d c%0d",
                   i, got_d[i], got_a[i], got_c[i], lits[i], i, acc[i]);
        end
      end
    end
    tests++;
    if (ram_write_address !== 11'd3) begin
      fails++;
      $display("FAIL lit_wptr got %0d want 3", ram_write_address);
    end
  endtask

  task automatic test_offset1();
    int a0, a;
    do_reset();
    send(1, 8'h55, 0, 0, a0);
    send(0, 8'h00, 11'd1, 12'd5, a);
    while (cyc != a + 6) @(negedge clk);
    tests++;
    if (tok_ready !== 1'b0) begin
      fails++;
      $display("FAIL off1_ready_last got %b want 0", tok_ready);
    end
    @(negedge clk);
    tests++;
    if (tok_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL off1_ready_back got %b%b want 10", tok_ready, busy);
    end
    tests++;
    if (got_d.size() != 6) begin
      fails++;
      $display("FAIL off1_count got %0d want 6", got_d.size());
    end else begin
      tests++;
      if (got_c[1] != a + 2 || got_c[5] != a + 6) begin
        fails++;
        $display("FAIL off1_timing got %0d..%0d want %0d..%0d",
                 got_c[1], got_c[5], a + 2, a + 6);
      end
      for (int i = 1; i < 6; i++) begin
        tests++;
        if (got_d[i] !== 8'h55 || got_c[i] != got_c[i-1] + 1 + (i == 1 ? 1 : 0) - (i == 1 ? 0 : 0) && i > 1) begin
          fails++;
          $display("FAIL off1_byte%0d got %h c%0d want 55", i, got_d[i], got_c[i]);
        end
      end
    end
    tests++;
    if (ram_write_address !== 11'd6) begin
      fails++;
      $display("FAIL off1_wptr got %0d want 6", ram_write_address);
    end
  endtask

  task automatic test_overlap(input int mode);
    int a;
    int w0;
    logic [7:0] want [10] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 1};
    do_reset();
    bp_mode = mode;
    bp_i = 0;
    stall_viol = 0;
    w0 = wr_cnt;
    for (int i = 1; i <= 3; i++) send(1, 8'(i), 0, 0, a);
    send(0, 8'h00, 11'd3, 12'd7, a);
    wait_idle();
    bp_mode = 0;
    tests++;
    if (got_d.size() != 10) begin
      fails++;
      $display("FAIL ovl%0d_count got %0d want 10", mode, got_d.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        tests++;
        if (got_d[i] !== want[i] || got_a[i] !== 11'(i) || !got_w[i]) begin
          fails++;
          $display("FAIL ovl%0d_byte%0d got %h@%0d want %h@%0d",
                   mode, i, got_d[i], got_a[i], want[i], i);
        end
      end
    end
    tests++;
    if (wr_cnt - w0 != 10) begin
      fails++;
      $display("FAIL ovl%0d_writes got %0d want 10", mode, wr_cnt - w0);
    end
    tests++;
    if (stall_viol != 0) begin
      fails++;
      $display("FAIL ovl%0d_stall got %0d changes want 0", mode, stall_viol);
    end
  endtask

  task automatic test_wrap();
    int a;
    do_reset();
    for (int i = 0; i < 2046; i++) send(1, 8'($urandom), 0, 0, a);
    send(0, 8'h00, 11'd2, 12'd4, a);
    wait_idle();
    tests++;
    if (got_d.size() != exp_d.size()) begin
      fails++;
      $display("FAIL wrap_count got %0d want %0d", got_d.size(), exp_d.size());
    end else begin
      for (int i = 2040; i < got_d.size(); i++) begin
        tests++;
        if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i] || !got_w[i]) begin
          fails++;
          $display("FAIL wrap_byte%0d got %h@%0d want %h@%0d",
                   i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
        end
      end
      tests++;
      if (exp_a[2049] !== 11'd1 || got_a[2049] !== 11'd1) begin
        fails++;
        $display("FAIL wrap_last_addr got %0d want 1", got_a[2049]);
      end
    end
  endtask

  task automatic test_illegal_reset();
    int a;
    do_reset();
    send(0, 8'h00, 11'd0, 12'd3, a);
    @(negedge clk);
    tests++;
    if (err !== 1'b1 || busy !== 1'b0 || got_d.size() != 0) begin
      fails++;
      $display("FAIL illegal_off0 got err=%b busy=%b n=%0d want 1 0 0",
               err, busy, got_d.size());
    end
    @(posedge clk);
    #1;
    send(0, 8'h00, 11'd5, 12'd0, a);
    send(1, 8'h99, 0, 0, a);
    @(negedge clk);
    tests++;
    if (err !== 1'b1 || got_d.size() != 1 || ram_write_address !== 11'd1) begin
      fails++;
      $display("FAIL illegal_sticky got err=%b n=%0d w=%0d want 1 1 1",
               err, got_d.size(), ram_write_address);
    end
    @(posedge clk);
    #1;
    send(0, 8'h00, 11'd1, 12'd10, a);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, out_valid, err} !== 3'b000 || ram_write_address !== 11'd0) begin
      fails++;
      $display("FAIL midcopy_reset got b=%b v=%b e=%b w=%0d want 0 0 0 0",
               busy, out_valid, err, ram_write_address);
    end
    do_reset();
  endtask

  task automatic test_random();
    int a;
    int made;
    int o, l;
    do_reset();
    bp_mode = 2;
    made = 0;
    for (int t = 0; t < 80; t++) begin
      if (made == 0 || ($urandom % 2) == 0) begin
        send(1, 8'($urandom), 0, 0, a);
        made++;
      end else begin
        o = 1 + int'($urandom % ((made < 2047) ? made : 2047));
        l = 1 + int'($urandom % 20);
        send(0, 8'h00, 11'(o), 12'(l), a);
        made += l;
      end
    end
    wait_idle();
    bp_mode = 0;
    tests++;
    if (got_d.size() != exp_d.size()) begin
      fails++;
      $display("FAIL rand_count got %0d want %0d", got_d.size(), exp_d.size());
    end else begin
      for (int i = 0; i < got_d.size(); i++) begin
        tests++;
        if (got_d[i] !== exp_d[i] || got_a[i] !== exp_a[i] || !got_w[i]) begin
          fails++;
          $display("FAIL rand_byte%0d got %h@%0d want %h@%0d",
                   i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
        end
      end
    end
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL rand_err got %b want 0", err);
    end
  endtask

  initial begin
    test_reset();
    test_literals();
    test_offset1();
    test_overlap(0);
    test_overlap(1);
    test_wrap();
    test_illegal_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lzs_copy_engine.md
# lzs_copy_engine

LZS decode copy engine sitting between the token parser and the 2 KB history RAM. Each token is either a literal byte or an (offset, length) back-reference. The block emits decoded bytes on a ready/valid stream and writes every emitted byte into the history RAM. Back-references are served from the RAM at one byte per cycle, including overlapping copies where offset < length.

## Interface
Parameters:
- `AW`, 11, history address width (2048-byte window)
- `LEN_W`, 12, copy-length width

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `tok_valid`  in  1  token present
- `tok_ready`  out  1  token accepted when `tok_valid && tok_ready`
- `tok_literal`  in  1  1 = literal, 0 = back-reference
- `tok_data`  in  8  literal byte
- `tok_offset`  in  AW  back-reference distance, 1..2047
- `tok_length`  in  LEN_W  back-reference byte count, ≥1
- `out_valid`  out  1  decoded byte present
- `out_ready`  in  1  downstream accepts
- `out_data`  out  8  decoded byte
- `ram_read_address`  out  AW  to history RAM; RAM registers it, data is valid next cycle
- `ram_read_data`  in  8  from history RAM
- `ram_write_address`  out  AW  = `wptr`
- `ram_write_data`  out  8  = `out_data`
- `ram_write_valid`  out  1  = `out_valid && out_ready` (byte retires)
- `busy`  out  1  state != IDLE
- `err`  out  1  sticky illegal-token flag

## Operation
- Registers:
  - `wptr` (AW bits, next history write slot).
  - `off`, `remain` (LEN_W bits).
  - `pending` (RAM output holds the current copy byte).
  - `state`, either IDLE or COPY.
- **IDLE, literal:**
  - `out_valid = tok_valid`, `out_data = tok_data`, `tok_ready = out_ready`.
  - On retire: the byte is written at `wptr`, then `wptr` increments (mod 2^AW).
- **IDLE, back-reference:**
  - `tok_ready = 1`.
  - On accept: latch `off` and `remain`, clear `pending`, go to COPY.
- **Illegal tokens:**
  - A back-reference with `tok_offset == 0` or `tok_length == 0` is accepted and consumed.
  - It sets `err`, emits nothing and stays in IDLE.
- **COPY:**
  - `tok_ready = 0`.
  - `out_valid = pending`, `out_data = ram_read_data`.
  - `ram_read_address = (wptr + retire) − off`, mod 2^AW, where `retire = out_valid && out_ready`.
  - `pending` is set to 1 after the first address cycle and stays 1 while `remain > 0`.
  - On retire: write at `wptr`, `wptr++`, `remain--`.
  - When `remain` hits 0 on a retire, clear `pending` and return to IDLE.
- **Overlap:** offset 1..length−1 must be correct. The RAM's read-after-write behaviour (address registered on the same edge as the write, data read after it) makes the byte just written visible to the next read. No forwarding logic is required.
- **Stall:** while `out_ready = 0`, `ram_read_address` and all state hold. The RAM re-latches the same address, so `out_data` stays stable.
- **Wrap:** `wptr` and the address subtraction wrap modulo 2048. Offsets reaching before byte 0 of the stream read stale or uninitialised RAM; this is not flagged.
- `err` clears only on `rst`.

## Timing
- Reset values:
  - `wptr = 0`, `state = IDLE`, `pending = 0`, `err = 0`, `busy = 0`.
  - `out_valid = 0`, `ram_write_valid = 0`.
  - `tok_ready` is 1 (IDLE, with the literal path following `out_ready`).
- Literal latency: 0 cycles, combinational pass-through.
- Back-reference:
  - accept at cycle a
  - first read address at a+1
  - first `out_valid` at a+2
  - then 1 byte/cycle under continuous `out_ready`
  - the last byte retires at a+1+L
  - `tok_ready` is high again at a+2+L
- Reset mid-copy aborts the copy immediately. Bytes already retired remain in the RAM.

## Configuration
- **`LZS_COPY_OUT_REG_EN`:**
  - Defined: `out_valid` and `out_data` come from a 2-entry skid register. This adds 1 cycle latency to both the literal and copy paths, and `tok_ready`/`out_ready` are no longer combinationally coupled.
  - The RAM write occurs when a byte enters the skid register, not when it leaves it.
  - The copy engine stalls only when the skid register is full.
  - Throughput stays 1 byte/cycle.
  - Undefined: combinational output exactly as described above.

## Test plan
- **Literals:** literals 0x41, 0x42, 0x43 with `out_ready = 1` -> out 41, 42, 43 on the accept cycles. RAM writes at addresses 0, 1, 2; `wptr = 3`.
- **Offset-1 run:** literal 0x55, then back-reference (offset 1, length 5) -> five bytes 0x55, first at accept+2, consecutive; `wptr = 6`; `tok_ready` high at accept+7.
- **Overlapping copy:** literals 01, 02, 03, then (offset 3, length 7) -> 01 02 03 01 02 03 01.
- **Backpressure:** the same copy with `out_ready` toggling 1,0,0,1,… -> identical byte sequence, `out_data` stable during stalls, exactly 7 RAM writes.
- **Wrap:** 2046 literals, then (offset 2, length 4) -> writes at 2046, 2047, 0, 1 with correct values; reads wrap at 2047→0.
- **Illegal and reset:** offset 0 -> `err = 1`, no output. Then assert `rst` in the middle of a length-10 copy -> `busy = 0`, `out_valid = 0`, `wptr = 0`, `err = 0` immediately.
